// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns fetch_pc and issues sequential fetches to a memory with a 1-cycle read latency.
// It queues the returned {pc, inst} pairs for decode. Optional macro IFQ_ALIGN_CHECK_EN adds redirect alignment checking.
module inst_fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic                     imem_req,
  output logic [WIDTH-1:0]         imem_addr,
  input  logic [WIDTH-1:0]         imem_rdata,
  output logic                     dec_valid,
  output logic [WIDTH-1:0]         dec_inst,
  output logic [WIDTH-1:0]         dec_pc,
  input  logic                     dec_ready,
`ifdef IFQ_ALIGN_CHECK_EN
  output logic                     fetch_misalign,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] tag;
  logic             inflight;
  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] redirect_target;

  // Decode handshake: a transfer happens on a rising edge where dec_valid and dec_ready
  // are both high; dec_valid never depends on dec_ready and the head is stable while stalled.
  assign dec_valid = (count != '0);
  assign pop       = dec_valid & dec_ready;
  assign push      = inflight & ~redirect;
  assign dec_inst  = inst_mem[rd_ptr];
  assign dec_pc    = pc_mem[rd_ptr];
  assign imem_addr = fetch_pc;

  // Credit check counts the outstanding response but not a same-cycle pop.
  assign imem_req  = rst & ~redirect & ((count + CW'(inflight)) < DEPTH_C);

`ifdef IFQ_ALIGN_CHECK_EN
  assign redirect_target = {redirect_pc[WIDTH-1:2], 2'b00};
`else
  assign redirect_target = redirect_pc;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      tag      <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (imem_req) begin
        inflight <= 1'b1;
        tag      <= fetch_pc;
        fetch_pc <= fetch_pc + WIDTH'(4);
      end else if (push) begin
        inflight <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= tag;
    end
  end

`ifdef IFQ_ALIGN_CHECK_EN
  // Sticky until the next redirect, which re-evaluates it.
  always_ff @(posedge clk) begin
    if (!rst)          fetch_misalign <= 1'b0;
    else if (redirect) fetch_misalign <= |redirect_pc[1:0];
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: memory model returns ~addr, delivered PCs are checked against an expected queue.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic [2:0]  count;
`ifdef IFQ_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  inst_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_inst    (dec_inst),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
`ifdef IFQ_ALIGN_CHECK_EN
    .fetch_misalign (fetch_misalign),
`endif
    .count       (count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: scoreboard any handshake, cross the edge, then return memory data for a captured request.
  task automatic tick();
    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] e;
    #2;
    req_s  = imem_req;
    addr_s = imem_addr;
    if (dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_delivery", dec_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_dec_pc", dec_pc, e);
        check("sb_dec_inst", dec_inst, ~e);
      end
    end
    @(posedge clk);
    #1;
    imem_rdata = req_s ? ~addr_s : 32'hBAD0_BAD0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    redirect  = 1'b0;
    dec_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_valid", dec_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
  endtask

  task automatic drain(input string tag);
    dec_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    dec_ready = 1'b0;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0; imem_rdata = '0;

    // 1: streaming with decode always ready
    do_reset();
    rst = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    #1;
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 32'h0);
    tick();
    check("t1_valid_n1", dec_valid, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t1_no_gap", dec_valid, 1);
      tick();
    end
    dec_ready = 1'b0;
    check("t1_all_seen", exp_q.size(), 0);

    // 2: decode stalled, fill then release
    do_reset();
    rst = 1'b1;
    repeat (5) tick();
    #1;
    check("t2_count", count, 4);
    check("t2_req", imem_req, 0);
    check("t2_addr", imem_addr, 32'h10);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    drain("t2_drain");

    // 3: redirect with count=3 and a response in flight
    do_reset();
    rst = 1'b1;
    repeat (4) tick();
    check("t3_count3", count, 3);
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    check("t3_req_blocked", imem_req, 0);
    tick();
    redirect = 1'b0;
    check("t3_count0", count, 0);
    check("t3_valid0", dec_valid, 0);
    #1;
    check("t3_req", imem_req, 1);
    check("t3_addr", imem_addr, 32'h100);
    tick();
    check("t3_valid_n1", dec_valid, 0);
    tick();
    check("t3_valid_n2", dec_valid, 1);
    check("t3_pc_n2", dec_pc, 32'h100);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    drain("t3_drain");

    // 4: redirect coinciding with handshake on 0x8, then back-to-back redirects
    do_reset();
    rst = 1'b1; dec_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    repeat (4) tick();
    check("t4_head", dec_pc, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check("t4_consumed", exp_q.size(), 0);
    check("t4_count0", count, 0);
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    drain("t4_drain");
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    #1;
    check("t4_last_wins", imem_addr, 32'h400);
    exp_q.push_back(32'h400); exp_q.push_back(32'h404);
    drain("t4_b2b_drain");

    // 5: one-cycle reset mid-stream with count=2
    do_reset();
    rst = 1'b1;
    repeat (3) tick();
    check("t5_count2", count, 2);
    rst = 1'b0;
    tick();
    check("t5_count", count, 0);
    check("t5_valid", dec_valid, 0);
    check("t5_req", imem_req, 0);
    check("t5_addr", imem_addr, 32'h0);
    rst = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    drain("t5_drain");

    // 6: fetch address wrap
    do_reset();
    rst = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    drain("t6_wrap");

`ifdef IFQ_ALIGN_CHECK_EN
    do_reset();
    rst = 1'b1;
    check("t6_misalign_rst", fetch_misalign, 0);
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    check("t6_misalign_set", fetch_misalign, 1);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    drain("t6_align_drain");
    check("t6_misalign_sticky", fetch_misalign, 1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check("t6_misalign_clr", fetch_misalign, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
